// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider (one quotient bit per clock), signed/unsigned, divide-by-zero flag.
// Optional macro SEQ_DIV_ABORT_EN adds an abort input that cancels an in-flight op.
module seq_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Clear_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   dmag_q, dmag_d;
  logic [WIDTH-1:0]   prem_q, prem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               zpend_q, zpend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    dmag_d  = dmag_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zpend_d = zpend_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    amag    = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
    bmag    = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
    shifted = {prem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dmag_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          sgn_d   = is_signed;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        quo_d  = amag;
        dmag_d = bmag;
        negq_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
        negr_d = sgn_q & dvd_q[WIDTH-1];
        if (dvs_q == '0) begin
          quot_d  = '1;
          rem_d   = dvd_q;
          dbz_d   = 1'b1;
          zpend_d = 1'b1;
          // Pass through FIX untouched so the zero case lands in DONE after edge 2
          state_d = S_FIX;
        end else begin
          prem_d  = '0;
          zpend_d = 1'b0;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        quo_d  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        prem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (!zpend_q) begin
          quot_d = negq_q ? -quo_q : quo_q;
          rem_d  = negr_q ? -prem_q : prem_q;
          dbz_d  = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef SEQ_DIV_ABORT_EN
    if (abort && (state_q == S_PREP || state_q == S_ITER || state_q == S_FIX)) begin
      state_d = S_IDLE;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
    end
`endif

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      dmag_q  <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zpend_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      dmag_q  <= dmag_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zpend_q <= zpend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
